// File: rtl/ins_fetch_if.sv
// Bundle of the fetch unit's control, instruction-memory and datapath signals.
// The master modport is the fetch unit; the slave modport is the memory/datapath side.
interface ins_fetch_if #(
  parameter int word_size  = 8,
  parameter int index_size = 4
);
  logic                  start;
  logic                  stall;
  logic [word_size-1:0]  ins_val;
  logic                  acc_zero;
  logic [word_size-1:0]  reg_data;
  logic [index_size-1:0] prog_count;
  logic [word_size-1:0]  ir;
  logic                  exec_en;
  logic [3:0]            reg_sel;
  logic                  halted;

  modport master (
    input  start, stall, ins_val, acc_zero, reg_data,
    output prog_count, ir, exec_en, reg_sel, halted
  );

  modport slave (
    output start, stall, ins_val, acc_zero, reg_data,
    input  prog_count, ir, exec_en, reg_sel, halted
  );
endinterface

// File: rtl/ins_fetch.sv
// Two-phase instruction fetch/execute sequencer: FETCH latches the instruction,
// EXEC strobes the datapath and resolves the next program counter (jumps, halt).
module ins_fetch #(
  parameter int word_size  = 8,
  parameter int index_size = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ins_fetch_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [3:0] OP_JR   = 4'b0110;
  localparam logic [3:0] OP_JI   = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t                state_q, state_d;
  logic [index_size-1:0] pc_q, pc_d;
  logic [word_size-1:0]  ir_q, ir_d;
  logic                  exec_en;
  logic [3:0]            opcode;
  logic [index_size-1:0] pc_inc;
  logic                  unused_reg_data;

  assign opcode = ir_q[7:4];
  // Natural width of the add gives the modulo-16 wrap for free.
  assign pc_inc = pc_q + index_size'(1);
  assign unused_reg_data = ^bus.reg_data[word_size-1:index_size];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    exec_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH: begin
        if (!bus.stall) begin
          ir_d    = bus.ins_val;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!bus.stall) begin
          exec_en = 1'b1;
          state_d = FETCH;
          case (opcode)
            OP_JR:   pc_d = bus.acc_zero ? bus.reg_data[index_size-1:0] : pc_inc;
            OP_JI:   pc_d = bus.acc_zero ? ir_q[index_size-1:0] : pc_inc;
            OP_HALT: state_d = HALTED;
            default: pc_d = pc_inc;
          endcase
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.prog_count = pc_q;
  assign bus.ir         = ir_q;
  assign bus.exec_en    = exec_en;
  assign bus.reg_sel    = ir_q[3:0];
  assign bus.halted     = (state_q == HALTED);

endmodule

// File: tb/tb_ins_fetch.sv
// Directed and randomized program runs checked cycle by cycle against an
// instruction-level model of the fetch sequencer.
module tb_ins_fetch;

  logic clk = 1'b0;
  logic rst_n;

  ins_fetch_if #(.word_size(8), .index_size(4)) bus ();

  ins_fetch #(.word_size(8), .index_size(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem  [16];
  logic [7:0] regs [16];

  assign bus.ins_val  = mem[bus.prog_count];
  assign bus.reg_data = regs[bus.reg_sel];

  int total = 0;
  int bad   = 0;
  int execs = 0;

  // Model: running program, halted flag, whether the next unstalled cycle executes
  bit         m_run;
  bit         m_halt;
  bit         m_exec_phase;
  logic [3:0] m_pc;
  logic [7:0] m_ir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run        = 1'b0;
    m_halt       = 1'b0;
    m_exec_phase = 1'b0;
    m_pc         = 4'd0;
    m_ir         = 8'd0;
  endfunction

  // Instruction-level semantics of the next address after executing ir at pc.
  function automatic logic [3:0] next_addr(input logic [7:0] ins, input logic [3:0] pc, input bit acc);
    logic [4:0] seq;
    seq = {1'b0, pc} + 5'd1;
    if (ins[7:4] == 4'h6 && acc) return regs[ins[3:0]][3:0];
    if (ins[7:4] == 4'h7 && acc) return ins[3:0];
    return seq[3:0];
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (m_halt) begin
      // frozen until reset
    end else if (!m_run) begin
      if (bus.start) begin
        m_run        = 1'b1;
        m_pc         = 4'd0;
        m_exec_phase = 1'b0;
      end
    end else if (!bus.stall) begin
      if (!m_exec_phase) begin
        m_ir         = mem[m_pc];
        m_exec_phase = 1'b1;
      end else begin
        m_exec_phase = 1'b0;
        if (m_ir[7:4] == 4'hF) begin
          m_halt = 1'b1;
          m_run  = 1'b0;
        end else begin
          m_pc = next_addr(m_ir, m_pc, bus.acc_zero);
        end
      end
    end
  endfunction

  // Called 1 time unit after a rising edge with this cycle's inputs already set.
  task automatic cycle();
    #1;
    check("exec_en", bus.exec_en, (m_run && m_exec_phase && !bus.stall) ? 1 : 0);
    check("prog_count", bus.prog_count, m_pc);
    check("ir", bus.ir, m_ir);
    check("halted", bus.halted, m_halt);
    check("reg_sel", bus.reg_sel, m_ir[3:0]);
    if (bus.exec_en === 1'b1) execs++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    bus.start = 1'b0;
    bus.stall = 1'b0;
    run(2);
    rst_n = 1'b1;
    execs = 0;
    cycle();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 8'h00;
      regs[i] = 8'h00;
    end
  endtask

  initial begin
    int e0;
    clear_mem();
    rst_n        = 1'b1;
    bus.start    = 1'b0;
    bus.stall    = 1'b0;
    bus.acc_zero = 1'b0;
    model_reset();

    // Reset state, asserted between edges
    #2 rst_n = 1'b0;
    #1;
    check("rst_pc", bus.prog_count, 0);
    check("rst_ir", bus.ir, 0);
    check("rst_exec", bus.exec_en, 0);
    check("rst_halt", bus.halted, 0);
    @(posedge clk);
    #1;
    do_reset();

    // Sequential program ending in HALT
    mem[0] = 8'hD8; mem[1] = 8'h51; mem[2] = 8'hD5; mem[3] = 8'hF0;
    pulse_start();
    run(10);
    check("seq_execs", execs, 4);
    check("seq_pc", bus.prog_count, 3);
    check("seq_halted", bus.halted, 1);
    check("seq_ir", bus.ir, 8'hF0);
    // start and stall ignored once halted
    bus.stall = 1'b1;
    pulse_start();
    bus.stall = 1'b0;
    run(3);
    check("halt_hold_execs", execs, 4);
    check("halt_hold_pc", bus.prog_count, 3);

    // Jump-immediate taken and not taken
    for (int t = 0; t < 2; t++) begin
      clear_mem();
      mem[8] = 8'h7A;
      do_reset();
      bus.acc_zero = (t == 0);
      pulse_start();
      run(18);
      check("ji_pc", bus.prog_count, (t == 0) ? 10 : 9);
      run(4);
    end

    // Jump-register skips the HALT at address 4
    clear_mem();
    mem[3]  = 8'h67; mem[4] = 8'hF0; mem[6] = 8'hF0;
    regs[7] = 8'h05;
    do_reset();
    bus.acc_zero = 1'b1;
    pulse_start();
    run(8);
    check("jr_pc", bus.prog_count, 5);
    check("jr_not_halted", bus.halted, 0);
    run(6);
    check("jr_halted", bus.halted, 1);
    check("jr_halt_pc", bus.prog_count, 6);

    // All NOPs wrap 15 -> 0
    clear_mem();
    do_reset();
    bus.acc_zero = 1'b0;
    pulse_start();
    run(32);
    check("wrap_pc", bus.prog_count, 0);
    check("wrap_execs", execs, 16);
    check("wrap_halted", bus.halted, 0);

    // Stall for 3 cycles during EXEC of 11
    clear_mem();
    mem[0] = 8'h11; mem[1] = 8'hF0;
    do_reset();
    pulse_start();
    cycle();
    bus.stall = 1'b1;
    run(3);
    check("stall_execs", execs, 0);
    check("stall_ir", bus.ir, 8'h11);
    bus.stall = 1'b0;
    cycle();
    check("stall_release_execs", execs, 1);
    check("stall_pc", bus.prog_count, 1);

    // Async reset mid-EXEC, then wait in IDLE
    clear_mem();
    mem[0] = 8'h22;
    do_reset();
    pulse_start();
    cycle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_exec", bus.exec_en, 0);
    check("arst_ir", bus.ir, 0);
    check("arst_pc", bus.prog_count, 0);
    @(posedge clk);
    model_edge();
    #1;
    rst_n = 1'b1;
    e0 = execs;
    run(4);
    check("arst_idle_execs", execs, e0);
    pulse_start();
    run(2);
    check("arst_restart_execs", execs, e0 + 1);

    // Randomized programs with random stalls and flags
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        logic [3:0] op;
        case ($urandom_range(0, 9))
          0, 1:    op = 4'h6;
          2, 3:    op = 4'h7;
          4:       op = ($urandom_range(0, 2) == 0) ? 4'hF : 4'h0;
          default: op = 4'($urandom_range(0, 14));
        endcase
        mem[i]  = {op, 4'($urandom)};
        regs[i] = 8'($urandom);
      end
      do_reset();
      pulse_start();
      for (int c = 0; c < 80; c++) begin
        bus.stall    = ($urandom_range(0, 3) == 0);
        bus.acc_zero = $urandom_range(0, 1) == 1;
        bus.start    = ($urandom_range(0, 7) == 0);
        cycle();
      end
      bus.stall = 1'b0;
      bus.start = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ins_fetch.md
INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 Parameter word_size, default 8: instruction width in bits.
REQ-002 Parameter index_size, default 4: program counter width; address space 2^index_size = 16 instructions.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  leave IDLE and begin fetching at address 0.
REQ-006 stall  input  1  freeze all state (FETCH/EXEC) while high.
REQ-007 ins_val  input  word_size  instruction returned combinationally by instruction memory for prog_count.
REQ-008 acc_zero  input  1  ACC == 0 flag from datapath, valid throughout EXEC.
REQ-009 reg_data  input  word_size  register-file read data for reg_sel; low index_size bits used as jump target.
REQ-010 prog_count  output  index_size  registered address to instruction memory.
REQ-011 ir  output  word_size  registered current instruction.
REQ-012 exec_en  output  1  one-cycle strobe; datapath executes ir in this cycle.
REQ-013 reg_sel  output  4  combinational ir[3:0], register index for jump-register.
REQ-014 halted  output  1  high while in HALTED.

Function
REQ-015 The FSM shall have states IDLE, FETCH, EXEC, HALTED.
REQ-016 IDLE: start=1 -> FETCH with prog_count=0; else stay.
REQ-017 FETCH (stall=0): ir <= ins_val; -> EXEC next cycle.
REQ-018 EXEC: exec_en=1 exactly while state==EXEC and stall=0; exec_en=0 in all other states.
REQ-019 Opcode = ir[7:4], operand = ir[3:0].
REQ-020 EXEC, opcode 0110 (jump-register): acc_zero=1 -> prog_count <= reg_data[3:0]; else prog_count+1; -> FETCH.
REQ-021 EXEC, opcode 0111 (jump-immediate): acc_zero=1 -> prog_count <= ir[3:0]; else prog_count+1; -> FETCH.
REQ-022 EXEC, opcode 1111 (HALT): prog_count unchanged; -> HALTED; exec_en still pulses for that cycle.
REQ-023 EXEC, any other opcode (NOP, ALU, loads, shifts, undefined): prog_count <= prog_count+1; -> FETCH.
REQ-024 Increment shall wrap modulo 16 (15 -> 0) with no flag.
REQ-025 HALTED: all registers hold; start ignored; exit only via reset.
REQ-026 stall=1 in FETCH or EXEC: state, prog_count, ir hold; exec_en=0; resume identically when stall drops.
REQ-027 stall ignored in IDLE and HALTED.
REQ-028 Throughput: one instruction per 2 unstalled cycles; start-to-first exec_en latency = 2 cycles.
REQ-029 Branch target equal to current prog_count (self-loop) shall be legal and repeat the instruction.

Reset
REQ-030 rst_n=0 shall immediately force state=IDLE, prog_count=0, ir=0, exec_en=0, halted=0, regardless of clk.
REQ-031 Reset asserted mid-FETCH, mid-EXEC, or in HALTED shall abandon the instruction with no exec_en pulse.
REQ-032 After rst_n rises, block waits in IDLE for start.

Verification
REQ-033 Sequential: mem[0..3]=D8,51,D5,F0, start pulse -> prog_count 0,1,2,3; exec_en pulses on cycles 2,4,6,8 with ir D8,51,D5,F0; halted=1 after F0, prog_count stays 3.
REQ-034 Jump-immediate taken: ir=7A at prog_count 8, acc_zero=1 -> next prog_count=10; acc_zero=0 -> next prog_count=9.
REQ-035 Jump-register: ir=67 at prog_count 3, reg_sel=7, reg_data=05, acc_zero=1 -> next prog_count=5, HALT at address 4 skipped.
REQ-036 Wrap: all 16 words 00 (NOP) -> prog_count 15 then 0, no halt, exec_en continues.
REQ-037 Stall: stall=1 for 3 cycles during EXEC of 11 -> exec_en low those cycles, ir/prog_count held, exactly one exec_en after release.
REQ-038 Async reset: rst_n low between clock edges during EXEC -> outputs zero immediately; after release, IDLE until start.
